// File: rtl/spram_arb.sv
// Two-requester arbiter in front of one single-port RAM with byte write enables.
// Grant is combinational. A bounded burst counter stops one requester from starving the other.
module spram_arb #(
  parameter int unsigned RAM_AW    = 9,
  parameter int unsigned RAM_BS    = 16,
  parameter int unsigned RAM_WS    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset_n,
  input  logic                  req0_ce,
  input  logic [RAM_BS-1:0]     req0_we,
  input  logic [RAM_AW-1:0]     req0_a,
  input  logic [8*RAM_BS-1:0]   req0_d,
  output logic                  req0_gnt,
  output logic                  req0_qvalid,
  output logic [8*RAM_BS-1:0]   req0_q,
  input  logic                  req1_ce,
  input  logic [RAM_BS-1:0]     req1_we,
  input  logic [RAM_AW-1:0]     req1_a,
  input  logic [8*RAM_BS-1:0]   req1_d,
  output logic                  req1_gnt,
  output logic                  req1_qvalid,
  output logic [8*RAM_BS-1:0]   req1_q,
  output logic                  ram_cen,
  output logic [RAM_BS-1:0]     ram_wen,
  output logic [RAM_AW-1:0]     ram_a,
  output logic [8*RAM_BS-1:0]   ram_d,
  input  logic [8*RAM_BS-1:0]   ram_q
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

  if (RAM_WS < 1 || RAM_WS > 4) begin : g_bad_ws
    $error("spram_arb: RAM_WS must be in 1..4");
  end
  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
    $error("spram_arb: MAX_BURST must be in 1..16");
  end

  owner_t              r_owner;
  logic                r_last;
  logic [CW-1:0]       r_cnt;
  logic [RAM_WS-1:0]   r_pv;
  logic [RAM_WS-1:0]   r_pt;

  owner_t              w_owner_nxt;
  logic                w_last_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW-1:0]       w_cnt_inc;
  logic                w_cap;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_rd_issue;

  // State register: arbitration state plus the {valid, owner} read-return pipeline.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      r_owner <= OWN_NONE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_pv    <= '0;
      r_pt    <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      for (int i = RAM_WS - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
      r_pv[0] <= w_rd_issue;
      r_pt[0] <= w_gnt1;
    end
  end

  assign w_cap     = (r_cnt >= CW'(MAX_BURST));
  assign w_cnt_inc = w_cap ? r_cnt : r_cnt + CW'(1);

  // Next-state: pick the grant, then advance owner/last_served/burst count.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_nxt = OWN_NONE;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    if (req0_ce && req1_ce) begin
      unique case (r_owner)
        OWN_R0: begin
          w_gnt0 = !w_cap;
          w_gnt1 = w_cap;
        end
        OWN_R1: begin
          w_gnt1 = !w_cap;
          w_gnt0 = w_cap;
        end
        default: begin
          w_gnt0 = r_last;
          w_gnt1 = !r_last;
        end
      endcase
    end else begin
      w_gnt0 = req0_ce;
      w_gnt1 = req1_ce;
    end
    if (w_gnt0) begin
      w_owner_nxt = OWN_R0;
      w_last_nxt  = 1'b0;
      w_cnt_nxt   = (r_owner == OWN_R0) ? w_cnt_inc : CW'(1);
    end else if (w_gnt1) begin
      w_owner_nxt = OWN_R1;
      w_last_nxt  = 1'b1;
      w_cnt_nxt   = (r_owner == OWN_R1) ? w_cnt_inc : CW'(1);
    end
  end

  // Outputs: steer the granted requester onto the RAM port; idle port shows req0 values.
  always_comb begin
    req0_gnt   = w_gnt0;
    req1_gnt   = w_gnt1;
    ram_cen    = !(w_gnt0 || w_gnt1);
    ram_wen    = '1;
    ram_a      = req0_a;
    ram_d      = req0_d;
    w_rd_issue = 1'b0;
    if (w_gnt1) begin
      ram_a      = req1_a;
      ram_d      = req1_d;
      ram_wen    = ~req1_we;
      w_rd_issue = ~|req1_we;
    end else if (w_gnt0) begin
      ram_wen    = ~req0_we;
      w_rd_issue = ~|req0_we;
    end
  end

  assign req0_qvalid = r_pv[RAM_WS-1] && !r_pt[RAM_WS-1];
  assign req1_qvalid = r_pv[RAM_WS-1] &&  r_pt[RAM_WS-1];
  assign req0_q      = ram_q;
  assign req1_q      = ram_q;

endmodule

// File: tb/tb_spram_arb.sv
// Directed bench for spram_arb: one DUT with a behavioural RAM (RAM_WS=1) and
// a second DUT with RAM_WS=3 for read-latency and reset-discard checks.
module tb_spram_arb;

  logic         clk;
  logic         rst_n;
  logic         ce0, ce1;
  logic [15:0]  we0, we1;
  logic [8:0]   a0, a1;
  logic [127:0] d0, d1;
  logic         gnt0, gnt1, qv0, qv1;
  logic [127:0] q0, q1;
  logic         ram_cen;
  logic [15:0]  ram_wen;
  logic [8:0]   ram_a;
  logic [127:0] ram_d, ram_q;
  logic [127:0] mem [512];

  logic         rst3_n;
  logic         c3_ce0, c3_ce1;
  logic [15:0]  c3_we;
  logic [8:0]   c3_a;
  logic [127:0] c3_d;
  logic         g3_0, g3_1, qv3_0, qv3_1;
  logic [127:0] q3_0, q3_1;
  logic         cen3;
  logic [15:0]  wen3;
  logic [8:0]   a3;
  logic [127:0] dd3;
  logic [127:0] rq3;

  int n_vec = 0;
  int n_err = 0;

  spram_arb #(.RAM_AW(9), .RAM_BS(16), .RAM_WS(1), .MAX_BURST(4)) u_dut (
    .usr_clk(clk), .usr_reset_n(rst_n),
    .req0_ce(ce0), .req0_we(we0), .req0_a(a0), .req0_d(d0),
    .req0_gnt(gnt0), .req0_qvalid(qv0), .req0_q(q0),
    .req1_ce(ce1), .req1_we(we1), .req1_a(a1), .req1_d(d1),
    .req1_gnt(gnt1), .req1_qvalid(qv1), .req1_q(q1),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  spram_arb #(.RAM_AW(9), .RAM_BS(16), .RAM_WS(3), .MAX_BURST(4)) u_dut3 (
    .usr_clk(clk), .usr_reset_n(rst3_n),
    .req0_ce(c3_ce0), .req0_we(c3_we), .req0_a(c3_a), .req0_d(c3_d),
    .req0_gnt(g3_0), .req0_qvalid(qv3_0), .req0_q(q3_0),
    .req1_ce(c3_ce1), .req1_we(c3_we), .req1_a(c3_a), .req1_d(c3_d),
    .req1_gnt(g3_1), .req1_qvalid(qv3_1), .req1_q(q3_1),
    .ram_cen(cen3), .ram_wen(wen3), .ram_a(a3), .ram_d(dd3), .ram_q(rq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (!ram_cen) begin
      for (int b = 0; b < 16; b++)
        if (!ram_wen[b]) mem[ram_a][8*b +: 8] <= ram_d[8*b +: 8];
      if (&ram_wen) ram_q <= mem[ram_a];
    end
  end

  task automatic idle();
    ce0 = 1'b0; ce1 = 1'b0; we0 = '0; we1 = '0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst3_n = 1'b0;
    idle();
    c3_ce0 = 1'b0; c3_ce1 = 1'b0; c3_we = '0; c3_a = '0; c3_d = '0; rq3 = '0;
    @(negedge clk); #1;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      $display("FAIL reset_gnt got %b%b want 00", gnt0, gnt1); n_err++; end
    n_vec++;
    if (qv0 !== 1'b0 || qv1 !== 1'b0) begin
      $display("FAIL reset_qvalid got %b%b want 00", qv0, qv1); n_err++; end
    n_vec++;
    if (ram_cen !== 1'b1 || ram_wen !== 16'hFFFF) begin
      $display("FAIL reset_ram_idle got cen=%b wen=%h want 1 ffff", ram_cen, ram_wen); n_err++; end
    n_vec++;
    @(negedge clk);
    ce0 = 1'b1; ce1 = 1'b1; a0 = 9'h005; a1 = 9'h006;
    #1;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      $display("FAIL reset_contend got %b%b want 10", gnt0, gnt1); n_err++; end
    n_vec++;
    if (ram_cen !== 1'b0 || ram_a !== 9'h005) begin
      $display("FAIL reset_ram_drive got cen=%b a=%h want 0 005", ram_cen, ram_a); n_err++; end
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1; rst3_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [9:0] exp_g;
    exp_g = 10'b00_1111_0000;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      ce0 = 1'b1; ce1 = 1'b1;
      #1;
      if (gnt1 !== exp_g[k] || gnt0 !== !exp_g[k]) begin
        $display("FAIL rr_gnt[%0d] got %b%b want %b%b", k, gnt0, gnt1, !exp_g[k], exp_g[k]); n_err++; end
      n_vec++;
      if (k > 0) begin
        if (qv0 !== !exp_g[k-1] || qv1 !== exp_g[k-1]) begin
          $display("FAIL rr_qvalid[%0d] got %b%b want %b%b", k, qv0, qv1, !exp_g[k-1], exp_g[k-1]); n_err++; end
        n_vec++;
      end
    end
    @(negedge clk);
    idle();
    #1;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_cen !== 1'b1) begin
      $display("FAIL rr_end got gnt=%b%b cen=%b want 00 1", gnt0, gnt1, ram_cen); n_err++; end
    n_vec++;
    if (qv0 !== 1'b1 || qv1 !== 1'b0) begin
      $display("FAIL rr_last_qvalid got %b%b want 10", qv0, qv1); n_err++; end
    n_vec++;
    @(negedge clk); #1;
    if (qv0 !== 1'b0 || qv1 !== 1'b0) begin
      $display("FAIL rr_qvalid_one_shot got %b%b want 00", qv0, qv1); n_err++; end
    n_vec++;
  endtask

  task automatic test_solo();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle(); ce1 = 1'b1; a1 = 9'(k);
      #1;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        $display("FAIL solo_gnt[%0d] got %b%b want 01", k, gnt0, gnt1); n_err++; end
      n_vec++;
    end
    @(negedge clk);
    ce0 = 1'b1; ce1 = 1'b1;
    #1;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      $display("FAIL solo_saturated_yield got %b%b want 10", gnt0, gnt1); n_err++; end
    n_vec++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_read_after_write();
    @(negedge clk);
    idle(); ce0 = 1'b1; we0 = 16'hFFFF; a0 = 9'h010; d0 = {16{8'hA5}};
    #1;
    if (gnt0 !== 1'b1 || ram_cen !== 1'b0 || ram_wen !== 16'h0000 || ram_a !== 9'h010) begin
      $display("FAIL raw_write got gnt0=%b cen=%b wen=%h a=%h want 1 0 0000 010",
               gnt0, ram_cen, ram_wen, ram_a); n_err++; end
    n_vec++;
    @(negedge clk);
    idle(); ce1 = 1'b1; a1 = 9'h010;
    #1;
    if (gnt1 !== 1'b1 || ram_wen !== 16'hFFFF || ram_a !== 9'h010) begin
      $display("FAIL raw_read got gnt1=%b wen=%h a=%h want 1 ffff 010", gnt1, ram_wen, ram_a); n_err++; end
    n_vec++;
    if (qv0 !== 1'b0 || qv1 !== 1'b0) begin
      $display("FAIL raw_write_no_qvalid got %b%b want 00", qv0, qv1); n_err++; end
    n_vec++;
    @(negedge clk);
    idle();
    #1;
    if (qv1 !== 1'b1 || qv0 !== 1'b0) begin
      $display("FAIL raw_qvalid got %b%b want 01", qv0, qv1); n_err++; end
    n_vec++;
    if (q1 !== {16{8'hA5}}) begin
      $display("FAIL raw_data got %h want %h", q1, {16{8'hA5}}); n_err++; end
    n_vec++;
  endtask

  task automatic test_partial_write();
    logic [127:0] exp_q;
    exp_q = {{15{8'h11}}, 8'h3C};
    @(negedge clk);
    idle(); ce0 = 1'b1; we0 = 16'hFFFF; a0 = 9'h1FF; d0 = {16{8'h11}};
    @(negedge clk);
    idle(); ce0 = 1'b1; we0 = 16'h0001; a0 = 9'h1FF; d0 = 128'h3C;
    #1;
    if (ram_wen !== 16'hFFFE || ram_a !== 9'h1FF || qv0 !== 1'b0) begin
      $display("FAIL part_write got wen=%h a=%h qv0=%b want fffe 1ff 0", ram_wen, ram_a, qv0); n_err++; end
    n_vec++;
    @(negedge clk);
    idle(); ce1 = 1'b1; a1 = 9'h1FF;
    #1;
    if (gnt1 !== 1'b1 || qv0 !== 1'b0 || qv1 !== 1'b0) begin
      $display("FAIL part_read got gnt1=%b qv=%b%b want 1 00", gnt1, qv0, qv1); n_err++; end
    n_vec++;
    @(negedge clk);
    idle();
    #1;
    if (qv1 !== 1'b1 || q1 !== exp_q) begin
      $display("FAIL part_data got qv1=%b q=%h want 1 %h", qv1, q1, exp_q); n_err++; end
    n_vec++;
  endtask

  task automatic test_drop_ce();
    logic [6:0] exp_g1;
    logic [6:0] c0;
    logic [6:0] c1;
    exp_g1 = 7'b0111100;
    c0     = 7'b1111011;
    c1     = 7'b1111110;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      idle(); ce0 = c0[k]; ce1 = c1[k];
      #1;
      if (gnt1 !== exp_g1[k] || gnt0 !== !exp_g1[k]) begin
        $display("FAIL drop_gnt[%0d] got %b%b want %b%b", k, gnt0, gnt1, !exp_g1[k], exp_g1[k]); n_err++; end
      n_vec++;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_ws3_latency();
    @(negedge clk);
    c3_ce0 = 1'b1; c3_ce1 = 1'b0;
    #1;
    if (g3_0 !== 1'b1) begin
      $display("FAIL ws3_gnt got %b want 1", g3_0); n_err++; end
    n_vec++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      c3_ce0 = 1'b0;
      #1;
      if (qv3_0 !== (k == 3) || qv3_1 !== 1'b0) begin
        $display("FAIL ws3_qvalid[+%0d] got %b%b want %b0", k, qv3_0, qv3_1, (k == 3)); n_err++; end
      n_vec++;
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    c3_ce0 = 1'b1; c3_ce1 = 1'b0;
    #1;
    if (g3_0 !== 1'b1) begin
      $display("FAIL rmr_gnt0 got %b want 1", g3_0); n_err++; end
    n_vec++;
    @(negedge clk);
    c3_ce0 = 1'b0; c3_ce1 = 1'b1;
    #1;
    if (g3_1 !== 1'b1) begin
      $display("FAIL rmr_gnt1 got %b want 1", g3_1); n_err++; end
    n_vec++;
    @(negedge clk);
    c3_ce1 = 1'b0; rst3_n = 1'b0;
    #1;
    if (cen3 !== 1'b1 || qv3_0 !== 1'b0 || qv3_1 !== 1'b0) begin
      $display("FAIL rmr_in_reset got cen=%b qv=%b%b want 1 00", cen3, qv3_0, qv3_1); n_err++; end
    n_vec++;
    c3_ce0 = 1'b1;
    #1;
    if (cen3 !== 1'b0 || g3_0 !== 1'b1) begin
      $display("FAIL rmr_reset_ce got cen=%b gnt0=%b want 0 1", cen3, g3_0); n_err++; end
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst3_n = 1'b1; c3_ce0 = 1'b0;
      #1;
      if (qv3_0 !== 1'b0 || qv3_1 !== 1'b0) begin
        $display("FAIL rmr_discard[%0d] got %b%b want 00", k, qv3_0, qv3_1); n_err++; end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_solo();
    test_read_after_write();
    test_partial_write();
    test_drop_ce();
    test_ws3_latency();
    test_reset_mid_read();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
